// File: rtl/lcd_st7789_rx.sv
// Display-side receiver for a 4-wire ST7789-style SPI link. It oversamples the pins,
// rebuilds bytes, decodes the command set and emits addressed RGB565 pixel writes.
module lcd_st7789_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DISP_W      = 135,
    parameter int DISP_H      = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_rst,
    input  logic        lcd_cs,
    input  logic        lcd_scl,
    input  logic        lcd_sd,
    input  logic        lcd_rs,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_is_dat,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        pix_valid,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic [15:0] pix_data,
    output logic        sleep_out,
    output logic        disp_on,
    output logic        inv_on,
    output logic        err_window
);

    typedef enum logic [1:0] {S_CMD, S_ARGS, S_HI, S_LO} state_t;

    // Pin order {lcd_rst, rs, sd, scl, cs}; idle levels keep cs and lcd_rst inactive
    localparam logic [4:0] SYNC_IDLE = 5'b10001;
    localparam logic [15:0] XE_RST = 16'(DISP_W - 1);
    localparam logic [15:0] YE_RST = 16'(DISP_H - 1);

    logic [SYNC_STAGES-1:0][4:0] sync;
    logic        cs_s, scl_s, sd_s, rs_s, lrst_s, scl_q, rise;
    logic [2:0]  bitcnt;
    logic [6:0]  shreg;

    state_t      state;
    logic [1:0]  argcnt;
    logic [23:0] argbuf;
    logic        arg_row;
    logic [15:0] xs, xe, ys, ye, x, y;
    logic [7:0]  hi;
    logic        ram_bad;
    logic        swreset;

    assign {lrst_s, rs_s, sd_s, scl_s, cs_s} = sync[SYNC_STAGES-1];
    assign rise    = scl_s & ~scl_q;
    assign swreset = byte_valid & ~byte_is_dat & (byte_data == 8'h01);

    // Pin synchronisers plus the delayed SCL used for edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync  <= {SYNC_STAGES{SYNC_IDLE}};
            scl_q <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], {lcd_rst, lcd_rs, lcd_sd, lcd_scl, lcd_cs}};
            scl_q <= scl_s;
        end
    end

    // Byte assembly; panel reset wins over a byte completing in the same cycle
    always_ff @(posedge clk) begin
        if (!rst || !lrst_s) begin
            bitcnt      <= '0;
            shreg       <= '0;
            byte_valid  <= 1'b0;
            byte_data   <= '0;
            byte_is_dat <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (cs_s) begin
                bitcnt <= '0;
            end else if (rise) begin
                shreg  <= {shreg[5:0], sd_s};
                bitcnt <= bitcnt + 3'd1;
                if (bitcnt == 3'd7) begin
                    byte_valid  <= 1'b1;
                    byte_data   <= {shreg, sd_s};
                    byte_is_dat <= rs_s;
                end
            end
        end
    end

    // Command decoder, window registers and pixel address generator
    always_ff @(posedge clk) begin
        if (!rst || !lrst_s || swreset) begin
            // SWRESET still reports its own command pulse
            cmd_valid  <= rst & lrst_s;
            cmd_code   <= (rst & lrst_s) ? 8'h01 : 8'h00;
            state      <= S_CMD;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_data   <= '0;
            sleep_out  <= 1'b0;
            disp_on    <= 1'b0;
            inv_on     <= 1'b0;
            err_window <= 1'b0;
            xs         <= '0;
            xe         <= XE_RST;
            ys         <= '0;
            ye         <= YE_RST;
            x          <= '0;
            y          <= '0;
            argcnt     <= '0;
            argbuf     <= '0;
            arg_row    <= 1'b0;
            hi         <= '0;
            ram_bad    <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            pix_valid <= 1'b0;
            if (byte_valid && !byte_is_dat) begin
                cmd_valid <= 1'b1;
                cmd_code  <= byte_data;
                state     <= S_CMD;
                case (byte_data)
                    8'h10: sleep_out <= 1'b0;
                    8'h11: sleep_out <= 1'b1;
                    8'h20: inv_on    <= 1'b0;
                    8'h21: inv_on    <= 1'b1;
                    8'h28: disp_on   <= 1'b0;
                    8'h29: disp_on   <= 1'b1;
                    8'h2A, 8'h2B: begin
                        state   <= S_ARGS;
                        argcnt  <= '0;
                        arg_row <= byte_data[0];
                    end
                    8'h2C: begin
                        state   <= S_HI;
                        x       <= xs;
                        y       <= ys;
                        ram_bad <= (xs > xe) || (ys > ye);
                        if ((xs > xe) || (ys > ye)) err_window <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (byte_valid) begin
                case (state)
                    S_ARGS: begin
                        argcnt <= argcnt + 2'd1;
                        argbuf <= {argbuf[15:0], byte_data};
                        if (argcnt == 2'd3) begin
                            state <= S_CMD;
                            if (arg_row) begin
                                ys <= argbuf[23:8];
                                ye <= {argbuf[7:0], byte_data};
                            end else begin
                                xs <= argbuf[23:8];
                                xe <= {argbuf[7:0], byte_data};
                            end
                        end
                    end
                    S_HI: begin
                        hi    <= byte_data;
                        state <= S_LO;
                    end
                    S_LO: begin
                        state <= S_HI;
                        if (!ram_bad) begin
                            pix_valid <= 1'b1;
                            pix_x     <= x;
                            pix_y     <= y;
                            pix_data  <= {hi, byte_data};
                        end
                        if (x == xe) begin
                            x <= xs;
                            y <= (y == ye) ? ys : y + 16'd1;
                        end else begin
                            x <= x + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_st7789_rx.sv
// Scoreboard bench for lcd_st7789_rx: bytes, commands and pixels are queued as they are
// driven and compared in order when the receiver reports them.
module tb_lcd_st7789_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lcd_rst = 1'b1, lcd_cs = 1'b1, lcd_scl = 1'b0, lcd_sd = 1'b0, lcd_rs = 1'b0;
    logic        byte_valid, byte_is_dat, cmd_valid, pix_valid;
    logic [7:0]  byte_data, cmd_code;
    logic [15:0] pix_x, pix_y, pix_data;
    logic        sleep_out, disp_on, inv_on, err_window;

    int checks = 0;
    int errs   = 0;

    logic [8:0]  byte_q[$];
    logic [7:0]  cmd_q[$];
    logic [47:0] pix_q[$];

    lcd_st7789_rx dut (
        .clk(clk), .rst(rst), .lcd_rst(lcd_rst), .lcd_cs(lcd_cs), .lcd_scl(lcd_scl),
        .lcd_sd(lcd_sd), .lcd_rs(lcd_rs), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_is_dat(byte_is_dat), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .sleep_out(sleep_out), .disp_on(disp_on), .inv_on(inv_on), .err_window(err_window)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Output monitor: every reported event must match the head of its queue
    always @(negedge clk) begin
        if (byte_valid) begin
            if (byte_q.size() == 0) chk("byte unexpected", {byte_is_dat, byte_data}, 64'hx);
            else chk("byte", {byte_is_dat, byte_data}, byte_q.pop_front());
        end
        if (cmd_valid) begin
            if (cmd_q.size() == 0) chk("cmd unexpected", cmd_code, 64'hx);
            else chk("cmd", cmd_code, cmd_q.pop_front());
        end
        if (pix_valid) begin
            if (pix_q.size() == 0) chk("pix unexpected", {pix_x, pix_y, pix_data}, 64'hx);
            else chk("pix", {pix_x, pix_y, pix_data}, pix_q.pop_front());
        end
    end

    // One framed SPI byte (mode 0, MSB first); nbits<8 leaves a partial byte
    task automatic spi_byte(input logic [7:0] b, input logic rs, input int nbits);
        if (nbits == 8) begin
            byte_q.push_back({rs, b});
            if (!rs) cmd_q.push_back(b);
        end
        lcd_rs = rs;
        lcd_cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            lcd_sd = b[7-i];
            repeat (4) @(negedge clk);
            lcd_scl = 1'b1;
            repeat (4) @(negedge clk);
            lcd_scl = 1'b0;
        end
        repeat (4) @(negedge clk);
        lcd_cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic cmd(input logic [7:0] c);
        spi_byte(c, 1'b0, 8);
    endtask

    task automatic dat(input logic [7:0] d);
        spi_byte(d, 1'b1, 8);
    endtask

    task automatic win(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
        cmd(c);
        dat(s[15:8]); dat(s[7:0]); dat(e[15:8]); dat(e[7:0]);
    endtask

    task automatic push_pix(input logic [15:0] px, input logic [15:0] py, input logic [15:0] d);
        pix_q.push_back({px, py, d});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " strobes"}, {byte_valid, byte_data, byte_is_dat, cmd_valid, cmd_code, pix_valid}, 0);
        chk({tag, " pix"}, {pix_x, pix_y, pix_data}, 0);
        chk({tag, " flags"}, {sleep_out, disp_on, inv_on, err_window}, 0);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk_all_zero("reset");

        // Column/row windows {0,3,0,1}
        win(8'h2A, 16'd0, 16'd3);
        win(8'h2B, 16'd0, 16'd1);

        // Nine pixels: eight fill the window, the ninth wraps to the origin
        for (int p = 0; p < 9; p++)
            push_pix(16'(p % 4), 16'((p / 4) % 2), {8'(8'h10 + p), 8'(8'hA0 + p)});
        cmd(8'h2C);
        for (int p = 0; p < 9; p++) begin
            dat(8'(8'h10 + p));
            dat(8'(8'hA0 + p));
        end

        // Partial byte killed by CS, then DISPON
        spi_byte(8'hFF, 1'b0, 5);
        cmd(8'h29);
        chk("disp_on", disp_on, 1);
        chk("cmd_code 29", cmd_code, 8'h29);

        // Odd trailing pixel byte is abandoned by the next command
        push_pix(16'd0, 16'd0, 16'h5566);
        cmd(8'h2C);
        dat(8'h55); dat(8'h66); dat(8'h77);
        cmd(8'h11);
        chk("sleep_out", sleep_out, 1);

        cmd(8'h21);
        chk("inv_on", inv_on, 1);

        // Inverted column window: error flag, pixels swallowed
        win(8'h2A, 16'd5, 16'd2);
        chk("err before ramwr", err_window, 0);
        cmd(8'h2C);
        dat(8'h01); dat(8'h02); dat(8'h03); dat(8'h04);
        chk("err_window", err_window, 1);

        // Panel reset in the middle of a pixel
        win(8'h2A, 16'd0, 16'd3);
        cmd(8'h2C);
        dat(8'h12);
        lcd_rst = 1'b0;
        repeat (6) @(negedge clk);
        lcd_rst = 1'b1;
        repeat (6) @(negedge clk);
        chk_all_zero("lcd_rst");

        // Reset window is full width, so the second pixel goes to column 1
        push_pix(16'd0, 16'd0, 16'h0102);
        push_pix(16'd1, 16'd0, 16'h0304);
        cmd(8'h2C);
        dat(8'h01); dat(8'h02); dat(8'h03); dat(8'h04);

        // SWRESET reports itself then clears state
        cmd(8'h29);
        chk("disp_on pre swreset", disp_on, 1);
        cmd(8'h01);
        chk("disp_on post swreset", disp_on, 0);
        chk("cmd_code swreset", cmd_code, 8'h01);

        // One-cycle system reset
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("rst pulse");

        chk("bytes left", byte_q.size(), 0);
        chk("cmds left", cmd_q.size(), 0);
        chk("pix left", pix_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
